load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 57 +++++
 rtl/load_store_unit.sv | 127 ++++++++++++
 tb/tb_load_store_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM encoding, default memory depth.
package lsu_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned DEPTH_WORDS_DEFAULT = 1024;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte/halfword extraction for loads and read-modify-write merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       byte_off,
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_c,
  output logic [WIDTH-1:0] merge_c
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        sign;

  always_comb begin
    sel_byte = word[7:0];
    case (byte_off)
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      2'd3:    sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
    sel_half = byte_off[1] ? word[31:16] : word[15:0];
    // funct3[2] set means the unsigned (LBU/LHU) variant
    sign     = ~funct3[2];

    case (funct3[1:0])
      2'b00:   load_c = {{(WIDTH-8){sign & sel_byte[7]}}, sel_byte};
      2'b01:   load_c = {{(WIDTH-16){sign & sel_half[15]}}, sel_half};
      default: load_c = word;
    endcase
  end

  always_comb begin
    merge_c = word;
    case (funct3[1:0])
      2'b00: begin
        case (byte_off)
          2'd0:    merge_c[7:0]   = wdata[7:0];
          2'd1:    merge_c[15:8]  = wdata[7:0];
          2'd2:    merge_c[23:16] = wdata[7:0];
          default: merge_c[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (byte_off[1]) merge_c[31:16] = wdata[15:0];
        else             merge_c[15:0]  = wdata[15:0];
      end
      default: merge_c = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the EX stage and a word-addressed data memory; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH       = XLEN,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_fault,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_data_write,
  output logic             mem_MemWrite,
  output logic             mem_MemRead,
  input  logic [WIDTH-1:0] mem_data_read
);

  localparam int unsigned      IDX_W     = WIDTH - 2;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH_WORDS);

  lsu_state_e       state_q, state_d;
  logic [WIDTH-1:0] addr_q, wdata_q, addr_n, wdata_n;
  logic [2:0]       funct3_q;
  logic             write_q;
  logic             take, funct_bad, misalign, fault_c, busy_n;
  logic [WIDTH-1:0] load_c, merge_c;
  logic [WIDTH-1:0] mem_address_d, mem_wdata_d, resp_rdata_d;
  logic             mem_read_d, mem_write_d, resp_valid_d, resp_fault_d, ready_d;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .funct3   (funct3_q),
    .byte_off (addr_q[1:0]),
    .word     (mem_data_read),
    .wdata    (wdata_q),
    .load_c   (load_c),
    .merge_c  (merge_c)
  );

  // Reject illegal encodings, misaligned halfword/word accesses and out-of-range word indices
  always_comb begin
    if (req_write) funct_bad = !(req_funct3 inside {SB, SH, SW});
    else           funct_bad = !(req_funct3 inside {LB, LH, LW, LBU, LHU});
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    fault_c  = funct_bad || misalign || (req_addr[WIDTH-1:2] >= DEPTH_IDX);
  end

  // Next state plus next values of every registered output
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          take = 1'b1;
          if (fault_c)              state_d = ST_RESP;
          else if (!req_write)      state_d = ST_LOAD;
          else if (req_funct3 == SW) state_d = ST_WRITE;
          else                      state_d = ST_MERGE;
        end
      end
      ST_LOAD:  state_d = ST_RESP;
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    addr_n  = take ? req_addr  : addr_q;
    wdata_n = take ? req_wdata : wdata_q;
    busy_n  = state_d inside {ST_LOAD, ST_MERGE, ST_WRITE};

    mem_address_d = busy_n ? {2'b00, addr_n[WIDTH-1:2]} : '0;
    mem_read_d    = state_d inside {ST_LOAD, ST_MERGE};
    mem_write_d   = (state_d == ST_WRITE);
    mem_wdata_d   = '0;
    if (state_d == ST_WRITE) mem_wdata_d = (state_q == ST_MERGE) ? merge_c : wdata_n;

    resp_valid_d = (state_d == ST_RESP);
    resp_fault_d = take && fault_c;
    resp_rdata_d = ((state_q == ST_LOAD) && !write_q) ? load_c : '0;
    ready_d      = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      funct3_q       <= '0;
      write_q        <= 1'b0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_fault     <= 1'b0;
      resp_rdata     <= '0;
      mem_address    <= '0;
      mem_data_write <= '0;
      mem_MemRead    <= 1'b0;
      mem_MemWrite   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        write_q  <= req_write;
      end
      req_ready      <= ready_d;
      resp_valid     <= resp_valid_d;
      resp_fault     <= resp_fault_d;
      resp_rdata     <= resp_rdata_d;
      mem_address    <= mem_address_d;
      mem_data_write <= mem_wdata_d;
      mem_MemRead    <= mem_read_d;
      mem_MemWrite   <= mem_write_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a behavioural word-addressed data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_write, mem_data_read;
  logic        mem_MemWrite, mem_MemRead;

  logic [31:0] mem [0:1023];
  logic        pl_we;
  logic [9:0]  pl_a;
  logic [31:0] pl_d;
  logic        addr_oob = 1'b0;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.WIDTH(32), .DEPTH_WORDS(1024)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_address    (mem_address),
    .mem_data_write (mem_data_write),
    .mem_MemWrite   (mem_MemWrite),
    .mem_MemRead    (mem_MemRead),
    .mem_data_read  (mem_data_read)
  );

  always #5 clk = ~clk;

  assign mem_data_read = mem[mem_address[9:0]];

  always @(posedge clk) begin
    if (mem_MemWrite) mem[mem_address[9:0]] <= mem_data_write;
    else if (pl_we)   mem[pl_a] <= pl_d;
    if ((mem_MemRead || mem_MemWrite) && (mem_address[31:10] != 22'd0)) addr_oob <= 1'b1;
  end

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          nwr;
    int          nrd;
  } vec_t;

  vec_t v [18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one op, then watch cycles after the accept edge until resp_valid (bounded)
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic flt,
                        output int nwr, output int nrd);
    int waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_op", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0; nwr = 0; nrd = 0; rd = 32'hFFFF_FFFF; flt = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_MemWrite) nwr++;
      if (mem_MemRead)  nrd++;
      if (resp_valid) begin
        lat = k;
        rd  = resp_rdata;
        flt = resp_fault;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  initial begin
    int          lat, nwr, nrd, seen;
    logic [31:0] rd;
    logic        flt;

    //      w     f3      addr        wdata         rdata         flt  lat wr rd
    v[0]  = '{1'b0, 3'b000, 32'h15,   32'h0,        32'hFFFF_FFAA, 1'b0, 2, 0, 1};
    v[1]  = '{1'b0, 3'b100, 32'h15,   32'h0,        32'h0000_00AA, 1'b0, 2, 0, 1};
    v[2]  = '{1'b0, 3'b101, 32'h16,   32'h0,        32'h0000_8899, 1'b0, 2, 0, 1};
    v[3]  = '{1'b0, 3'b001, 32'h16,   32'h0,        32'hFFFF_8899, 1'b0, 2, 0, 1};
    v[4]  = '{1'b0, 3'b010, 32'h14,   32'h0,        32'h8899_AABB, 1'b0, 2, 0, 1};
    v[5]  = '{1'b0, 3'b000, 32'h14,   32'h0,        32'hFFFF_FFBB, 1'b0, 2, 0, 1};
    v[6]  = '{1'b0, 3'b001, 32'h14,   32'h0,        32'hFFFF_AABB, 1'b0, 2, 0, 1};
    v[7]  = '{1'b0, 3'b100, 32'h17,   32'h0,        32'h0000_0088, 1'b0, 2, 0, 1};
    v[8]  = '{1'b0, 3'b010, 32'h102,  32'h0,        32'h0,         1'b1, 1, 0, 0};
    v[9]  = '{1'b0, 3'b001, 32'h15,   32'h0,        32'h0,         1'b1, 1, 0, 0};
    v[10] = '{1'b0, 3'b011, 32'h14,   32'h0,        32'h0,         1'b1, 1, 0, 0};
    v[11] = '{1'b1, 3'b010, 32'h1000, 32'h1,        32'h0,         1'b1, 1, 0, 0};
    v[12] = '{1'b1, 3'b100, 32'h14,   32'h1,        32'h0,         1'b1, 1, 0, 0};
    v[13] = '{1'b1, 3'b000, 32'h15,   32'h1234_5677, 32'h0,        1'b0, 3, 1, 1};
    v[14] = '{1'b0, 3'b010, 32'h14,   32'h0,        32'h8899_77BB, 1'b0, 2, 0, 1};
    v[15] = '{1'b1, 3'b010, 32'h24,   32'hA5A5_5A5A, 32'h0,        1'b0, 2, 1, 0};
    v[16] = '{1'b0, 3'b010, 32'h24,   32'h0,        32'hA5A5_5A5A, 1'b0, 2, 0, 1};
    v[17] = '{1'b0, 3'b101, 32'h26,   32'h0,        32'h0000_A5A5, 1'b0, 2, 0, 1};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; pl_we = 1'b0; pl_a = 10'd0; pl_d = 32'h0;
    preload(10'd5, 32'h8899_AABB);
    preload(10'd8, 32'h1122_3344);

    check("rst_ready",      {31'd0, req_ready},    32'd1);
    check("rst_resp_valid", {31'd0, resp_valid},   32'd0);
    check("rst_resp_fault", {31'd0, resp_fault},   32'd0);
    check("rst_resp_rdata", resp_rdata,            32'd0);
    check("rst_memwrite",   {31'd0, mem_MemWrite}, 32'd0);
    check("rst_memread",    {31'd0, mem_MemRead},  32'd0);
    check("rst_mem_addr",   mem_address,           32'd0);
    check("rst_mem_wdata",  mem_data_write,        32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(v[i].w, v[i].f3, v[i].a, v[i].d, lat, rd, flt, nwr, nrd);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
      check($sformatf("v%0d_rdata", i), rd, v[i].rd);
      check($sformatf("v%0d_fault", i), {31'd0, flt}, {31'd0, v[i].flt});
      check($sformatf("v%0d_memwrites", i), 32'(nwr), 32'(v[i].nwr));
      check($sformatf("v%0d_memreads", i), 32'(nrd), 32'(v[i].nrd));
      if (i == 13) check("sb_merged_word5", mem[5], 32'h8899_77BB);
    end

    // Reset while the SW is in its WRITE cycle must drop the write and the response
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("sw_in_write", {31'd0, mem_MemWrite}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_memwrite", {31'd0, mem_MemWrite}, 32'd0);
    check("abort_ready",    {31'd0, req_ready},    32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    check("abort_word8",   mem[8],   32'h1122_3344);

    // Halfword store into the upper half, then read the whole word back
    run_op(1'b1, 3'b001, 32'h22, 32'h0000_CAFE, lat, rd, flt, nwr, nrd);
    check("sh_latency",   32'(lat), 32'd3);
    check("sh_memwrites", 32'(nwr), 32'd1);
    check("sh_rdata",     rd,       32'd0);
    run_op(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, flt, nwr, nrd);
    check("sh_lw_rdata",  rd,       32'hCAFE_3344);
    check("sh_lw_fault",  {31'd0, flt}, 32'd0);

    check("mem_addr_in_range", {31'd0, addr_oob}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
